// File: rtl/mandel_pkg.sv
// Shared types and default widths for the Mandelbrot frame sequencer.
package mandel_pkg;

  localparam int unsigned XW   = 10;
  localparam int unsigned YW   = 10;
  localparam int unsigned CW   = 32;
  localparam int unsigned IW   = 15;
  localparam int unsigned FRAC = 28;  // Q4.28 fraction bits

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StWrite,
    StDone
  } seq_state_t;

endpackage

// File: rtl/mandel_raster_counter.sv
// Raster position counter: x/y counters, line-end/last-pixel flags and {y,x} address.
module mandel_raster_counter #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [XW-1:0]      x_size_i,
  input  logic [YW-1:0]      y_size_i,
  output logic               line_end_o,
  output logic               last_o,
  output logic [XW+YW-1:0]   addr_o
);

  logic [XW-1:0] x_q, x_d, x_last_q, x_last_d;
  logic [YW-1:0] y_q, y_d, y_last_q, y_last_d;

  assign line_end_o = (x_q == x_last_q);
  assign last_o     = line_end_o && (y_q == y_last_q);
  assign addr_o     = {y_q, x_q};

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    x_last_d = x_last_q;
    y_last_d = y_last_q;
    if (load_i) begin
      x_d      = '0;
      y_d      = '0;
      // A zero size behaves as a single pixel/line.
      x_last_d = (x_size_i == '0) ? '0 : x_size_i - XW'(1);
      y_last_d = (y_size_i == '0) ? '0 : y_size_i - YW'(1);
    end else if (en_i) begin
      if (line_end_o) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q      <= '0;
      y_q      <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      x_last_q <= x_last_d;
      y_last_q <= y_last_d;
    end
  end

endmodule

// File: rtl/mandel_frame_sequencer.sv
// Frame sequencer: raster-scans the pixel grid, issues coordinates to the iteration core and
// writes returned counts to the frame RAM. Optional MANDEL_SEQ_PERF_EN adds frame_cycles_o.
module mandel_frame_sequencer #(
  parameter int unsigned XW = mandel_pkg::XW,
  parameter int unsigned YW = mandel_pkg::YW,
  parameter int unsigned CW = mandel_pkg::CW,
  parameter int unsigned IW = mandel_pkg::IW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [XW-1:0]      x_size_i,
  input  logic [YW-1:0]      y_size_i,
  input  logic [CW-1:0]      re_min_i,
  input  logic [CW-1:0]      im_max_i,
  input  logic [CW-1:0]      delta_re_i,
  input  logic [CW-1:0]      delta_im_i,
  output logic               core_start_o,
  output logic [CW-1:0]      core_re_o,
  output logic [CW-1:0]      core_im_o,
  input  logic               core_done_i,
  input  logic [IW-1:0]      core_count_i,
  output logic               wr_en_o,
  output logic [XW+YW-1:0]   wr_addr_o,
  output logic [IW-1:0]      wr_data_o,
  output logic               busy_o,
`ifdef MANDEL_SEQ_PERF_EN
  output logic [31:0]        frame_cycles_o,
`endif
  output logic               frame_done_o
);

  import mandel_pkg::*;

  seq_state_t state_q, state_d;

  logic          accept;
  logic          line_end, last_pix;
  logic [CW-1:0] re_min_q, re_min_d, d_re_q, d_re_d, d_im_q, d_im_d;
  logic [CW-1:0] cur_re_q, cur_re_d, cur_im_q, cur_im_d;
  logic [CW-1:0] core_re_q, core_re_d, core_im_q, core_im_d;
  logic [IW-1:0] wr_data_q, wr_data_d;

  assign accept = (state_q == StIdle) && start_i;

  mandel_raster_counter #(
    .XW (XW),
    .YW (YW)
  ) u_raster (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .en_i       (state_q == StWrite),
    .x_size_i   (x_size_i),
    .y_size_i   (y_size_i),
    .line_end_o (line_end),
    .last_o     (last_pix),
    .addr_o     (wr_addr_o)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (core_done_i) state_d = StWrite;
      StWrite: state_d = last_pix ? StDone : StIssue;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    core_start_o = (state_q == StIssue);
    wr_en_o      = (state_q == StWrite);
    frame_done_o = (state_q == StDone);
    busy_o       = (state_q != StIdle);
  end

  assign core_re_o = core_re_q;
  assign core_im_o = core_im_q;
  assign wr_data_o = wr_data_q;

  always_comb begin
    re_min_d  = re_min_q;
    d_re_d    = d_re_q;
    d_im_d    = d_im_q;
    cur_re_d  = cur_re_q;
    cur_im_d  = cur_im_q;
    core_re_d = core_re_q;
    core_im_d = core_im_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      re_min_d = re_min_i;
      d_re_d   = delta_re_i;
      d_im_d   = delta_im_i;
      cur_re_d = re_min_i;
      cur_im_d = im_max_i;
    end
    if ((state_q == StWait) && core_done_i) wr_data_d = core_count_i;
    if (state_q == StWrite) begin
      if (line_end) begin
        cur_re_d = re_min_q;
        cur_im_d = cur_im_q - d_im_q;
      end else begin
        cur_re_d = cur_re_q + d_re_q;
      end
    end
    // Core coordinates only change on entry to ISSUE so they stay stable across WAIT/WRITE.
    if (state_d == StIssue) begin
      core_re_d = cur_re_d;
      core_im_d = cur_im_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      re_min_q  <= '0;
      d_re_q    <= '0;
      d_im_q    <= '0;
      cur_re_q  <= '0;
      cur_im_q  <= '0;
      core_re_q <= '0;
      core_im_q <= '0;
      wr_data_q <= '0;
    end else begin
      re_min_q  <= re_min_d;
      d_re_q    <= d_re_d;
      d_im_q    <= d_im_d;
      cur_re_q  <= cur_re_d;
      cur_im_q  <= cur_im_d;
      core_re_q <= core_re_d;
      core_im_q <= core_im_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef MANDEL_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (accept)                        cyc_d = '0;
    else if (busy_o && (cyc_q != '1)) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cyc_q <= '0;
    else         cyc_q <= cyc_d;
  end

  assign frame_cycles_o = cyc_q;
`endif

endmodule
